// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// register index width and the canonical NOP used when IF/ID is flushed.
package pipe_pkg;

    localparam int REG_W = 5;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FAULT    = 2'b10
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the
// stall/flush statistics.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + W'(1);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, EX redirect
// flushes and a memory-wait FSM with timeout watchdog, plus statistics.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [1:0]       state_o,
    output logic             fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [WC_W-1:0] wait_cnt;
    logic            mw;
    logic            lu;

    assign mw = mem_req & ~mem_ready;
    assign lu = ex_memread & ex_regwrite & (ex_rd != '0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_flush   = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (rst) begin
            if (state == ST_FAULT || mw) begin
                // Freeze: redirect and load-use are re-evaluated after release.
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end else if (ex_redirect) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (lu) begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mw) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // A dropped mem_req is treated as completion.
                    if (!mw) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                default: state <= ST_FAULT;
            endcase
        end
    end

    assign state_o = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_hold),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ifid_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a rule-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             ex_memread, ex_regwrite, ex_redirect;
    logic             mem_req, mem_ready;
    logic             pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_flush;
    logic             exmem_hold, memwb_bubble, fault;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_memread   (ex_memread),
        .ex_regwrite  (ex_regwrite),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .idex_flush   (idex_flush),
        .exmem_hold   (exmem_hold),
        .memwb_bubble (memwb_bubble),
        .state_o      (state_o),
        .fault        (fault),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 running, 1 waiting on memory, 2 faulted.
    int m_mode  = 0;
    int m_waits = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_fault = 0;

    typedef struct packed {
        logic pc_hold, ifid_hold, ifid_flush, idex_bubble, idex_flush, exmem_hold, memwb_bubble;
    } ctrl_t;

    function automatic bit mem_waiting();
        return mem_req && !mem_ready;
    endfunction

    function automatic bit load_use();
        bit reads_rd;
        reads_rd = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        return ex_memread && ex_regwrite && ex_rd != 0 && reads_rd;
    endfunction

    function automatic ctrl_t expected_ctrl();
        ctrl_t c;
        c = '0;
        if (rst === 1'b1) begin
            if (m_mode == 2 || mem_waiting()) begin
                c.pc_hold = 1; c.ifid_hold = 1; c.exmem_hold = 1; c.memwb_bubble = 1;
            end else if (ex_redirect) begin
                c.ifid_flush = 1; c.idex_flush = 1;
            end else if (load_use()) begin
                c.pc_hold = 1; c.ifid_hold = 1; c.idex_bubble = 1;
            end
        end
        return c;
    endfunction

    always @(posedge clk or negedge rst) begin
        ctrl_t c;
        if (!rst) begin
            m_mode = 0; m_waits = 0; m_stall = 0; m_flush = 0; m_fault = 0;
        end else begin
            c = expected_ctrl();
            if (c.pc_hold)    m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
            if (c.ifid_flush) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
            if (m_mode == 0 && mem_waiting()) begin
                m_mode = 1; m_waits = 1;
            end else if (m_mode == 1) begin
                if (!mem_waiting()) begin
                    m_mode = 0; m_waits = 0;
                end else if (m_waits >= TIMEOUT - 1) begin
                    m_mode = 2; m_fault = 1;
                end else begin
                    m_waits++;
                end
            end
        end
    end

    always @(negedge clk) begin
        ctrl_t e;
        e = expected_ctrl();
        check("pc_hold",      32'(pc_hold),      32'(e.pc_hold));
        check("ifid_hold",    32'(ifid_hold),    32'(e.ifid_hold));
        check("ifid_flush",   32'(ifid_flush),   32'(e.ifid_flush));
        check("idex_bubble",  32'(idex_bubble),  32'(e.idex_bubble));
        check("idex_flush",   32'(idex_flush),   32'(e.idex_flush));
        check("exmem_hold",   32'(exmem_hold),   32'(e.exmem_hold));
        check("memwb_bubble", 32'(memwb_bubble), 32'(e.memwb_bubble));
        check("state_o",      32'(state_o),      32'(m_mode));
        check("fault",        32'(fault),        32'(m_fault));
        check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check("flush_count",  32'(flush_count),  32'(m_flush));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_memread = 0; ex_regwrite = 0; ex_redirect = 0;
        mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_lw_x5_add();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 5;
        id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 7; id_use_rs2 = 1;
    endtask

    task automatic do_reset();
        #2 rst = 0;
        step();
        step();
        rst = 1;
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        // Hazard inputs present during reset must not reach the outputs.
        set_lw_x5_add();
        ex_redirect = 1;
        mem_req = 1;
        step();
        #2;
        check("rst_pc_hold", 32'(pc_hold), 0);
        check("rst_flush", 32'(ifid_flush), 0);
        check("rst_state", 32'(state_o), 0);
        idle_inputs();
        step();
        rst = 1;

        // Load-use: one-cycle bubble.
        step();
        set_lw_x5_add();
        #2;
        check("lu_pc_hold", 32'(pc_hold), 1);
        check("lu_bubble", 32'(idex_bubble), 1);
        step();
        ex_memread = 0; ex_regwrite = 0;
        #2;
        check("lu_release", 32'(pc_hold), 0);
        check("lu_stall_cnt", 32'(stall_cycles), 1);

        // No hazard: rd is x0, or rs1 matches but is not read.
        step();
        set_lw_x5_add(); ex_rd = 0;
        #2;
        check("lu_x0", 32'(pc_hold), 0);
        step();
        set_lw_x5_add(); id_use_rs1 = 0;
        #2;
        check("lu_unused_rs1", 32'(idex_bubble), 0);
        // Match through rs2.
        step();
        set_lw_x5_add(); id_rs1 = 3; id_rs2 = 5;
        #2;
        check("lu_rs2", 32'(idex_bubble), 1);

        // Redirect overrides load-use.
        step();
        set_lw_x5_add(); ex_redirect = 1;
        #2;
        check("redir_ifid_flush", 32'(ifid_flush), 1);
        check("redir_idex_flush", 32'(idex_flush), 1);
        check("redir_no_bubble", 32'(idex_bubble), 0);
        check("redir_no_hold", 32'(pc_hold), 0);
        step();
        idle_inputs();
        #2;
        check("redir_flush_cnt", 32'(flush_count), 1);
        check("redir_stall_cnt", 32'(stall_cycles), 2);

        // Memory wait of 3 cycles with a redirect pending: flush lands on the ready cycle.
        mem_req = 1; ex_redirect = 1;
        #2;
        check("mw_hold_run", 32'(pc_hold), 1);
        check("mw_no_flush", 32'(ifid_flush), 0);
        step(); step();
        #2;
        check("mw_state", 32'(state_o), 1);
        check("mw_exmem_hold", 32'(exmem_hold), 1);
        step();
        mem_ready = 1;
        #2;
        check("mw_ready_hold", 32'(pc_hold), 0);
        check("mw_ready_flush", 32'(ifid_flush), 1);
        step();
        idle_inputs();
        #2;
        check("mw_back_run", 32'(state_o), 0);
        check("mw_stall_cnt", 32'(stall_cycles), 5);
        check("mw_flush_cnt", 32'(flush_count), 2);

        // mem_req dropped mid-wait counts as completion.
        mem_req = 1;
        step();
        mem_req = 0;
        step();
        #2;
        check("drop_state", 32'(state_o), 0);

        // Asynchronous reset mid-wait.
        mem_req = 1;
        step();
        #2 rst = 0;
        #1;
        check("arst_pc_hold", 32'(pc_hold), 0);
        check("arst_state", 32'(state_o), 0);
        check("arst_stall", 32'(stall_cycles), 0);
        step();
        mem_req = 0;
        rst = 1;
        step();
        set_lw_x5_add();
        #2;
        check("arst_resume", 32'(idex_bubble), 1);
        step();
        idle_inputs();

        // Flush counter saturation.
        ex_redirect = 1;
        for (int i = 0; i < 20; i++) step();
        ex_redirect = 0;
        #2;
        check("flush_sat", 32'(flush_count), CNT_MAX);
        do_reset();

        // Timeout: 4 wait cycles then FAULT, sticky despite mem_ready.
        step();
        mem_req = 1;
        step(); step(); step();
        #2;
        check("to_still_wait", 32'(state_o), 1);
        step();
        #2;
        check("to_fault_state", 32'(state_o), 2);
        check("to_fault_flag", 32'(fault), 1);
        mem_ready = 1; ex_redirect = 1;
        for (int i = 0; i < 16; i++) step();
        #2;
        check("fault_sticky", 32'(state_o), 2);
        check("fault_freeze", 32'(pc_hold), 1);
        check("fault_no_flush", 32'(ifid_flush), 0);
        check("stall_sat", 32'(stall_cycles), CNT_MAX);
        idle_inputs();
        do_reset();
        step();
        #2;
        check("post_fault_run", 32'(state_o), 0);
        check("post_fault_clear", 32'(fault), 0);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline. Drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Handles three cases:
  - load-use hazards, by inserting one bubble into ID/EX;
  - control redirects resolved in EX (taken branch, jal, jalr), by flushing the wrong-path instructions;
  - multi-cycle data-memory accesses, using a valid/ready wait FSM with a timeout watchdog.
- Sits beside the pipeline registers. Also exports stall and flush statistics.

Parameters:
- REG_W, 5, register index width.
- CNT_W, 32, width of the statistics counters.
- TIMEOUT, 256, maximum number of consecutive memory-wait cycles before FAULT; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_rs1  in  REG_W  rs1 index of the instruction in ID
- id_rs2  in  REG_W  rs2 index of the instruction in ID
- id_use_rs1  in  1  the ID instruction reads rs1
- id_use_rs2  in  1  the ID instruction reads rs2
- ex_rd  in  REG_W  destination of the instruction in EX
- ex_memread  in  1  the EX instruction is a load
- ex_regwrite  in  1  the EX instruction writes the register file
- ex_redirect  in  1  the EX instruction redirects the PC this cycle
- mem_req  in  1  MEM stage has a valid data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its contents
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads with MemRead, MemWrite and RegWrite cleared
- idex_flush  out  1  ID/EX clears all contents
- exmem_hold  out  1  EX/MEM keeps its contents
- memwb_bubble  out  1  MEM/WB loads with RegWrite cleared
- state_o  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 FAULT
- fault  out  1  memory-timeout fault, sticky
- stall_cycles  out  CNT_W  number of cycles in which pc_hold was 1; saturating
- flush_count  out  CNT_W  number of redirect flushes taken; saturating

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait_cnt=0, fault=0, both counters=0. Every control output is forced to 0 while rst=0.
- Control outputs are combinational from the current state and inputs, so they take effect with zero latency. The state, wait_cnt and counters update on the rising edge of clk.
- mw (memory wait) = mem_req & !mem_ready.
- lu (load-use) = ex_memread & ex_regwrite & (ex_rd≠0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority per cycle, highest first:
  1. FAULT state: assert pc_hold, ifid_hold and exmem_hold, plus memwb_bubble. All other outputs 0.
  2. mw, in RUN or MEM_WAIT: same freeze as FAULT (pc_hold, ifid_hold, exmem_hold, memwb_bubble). ex_redirect and lu are ignored this cycle; they are re-evaluated once the freeze releases, because the EX and ID contents are held.
  3. ex_redirect: ifid_flush=1 and idex_flush=1, no hold. The redirect overrides lu because the ID instruction is on the wrong path.
  4. lu: pc_hold=1, ifid_hold=1, idex_bubble=1. This lasts exactly one cycle, because the next cycle the bubble occupies EX and lu evaluates to 0.
  5. Otherwise all control outputs are 0.
- FSM transitions:
  - RUN→MEM_WAIT when mw. wait_cnt is set to 1.
  - In MEM_WAIT:
    - mem_ready=1 → RUN, wait_cnt=0. In this cycle mw=0, so the pipeline advances.
    - !mem_ready and wait_cnt==TIMEOUT-1 → FAULT, fault=1.
    - Else wait_cnt increments.
  - mem_req dropping to 0 while in MEM_WAIT is a protocol error; treat it as completion (→RUN).
  - FAULT is left only by reset.
- Counters:
  - stall_cycles increments on every edge where pc_hold=1.
  - flush_count increments on every edge where ifid_flush=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - mw together with ex_redirect: freeze wins. The flush occurs in the cycle where mem_ready=1, and it is counted then.
  - lu together with mw: freeze only; no bubble is inserted while frozen.
- Reset mid-wait: returns immediately to RUN with counters cleared. No pending state survives.

Decomposition:
- Shared package pipe_pkg:
  - state encodings ST_RUN, ST_MEM_WAIT, ST_FAULT;
  - REG_W;
  - NOP instruction constant 32'h00000013, used by the IF/ID flush.
- One natural sub-module, sat_counter (width parameter, inc, async active-low reset), instantiated twice for the statistics counters.
- Hazard detection, priority logic and the FSM stay in the top module.

Test Plan:
- lw x5 in EX (ex_memread=1, ex_regwrite=1, ex_rd=5) and add x6,x5,x7 in ID (id_rs1=5, id_use_rs1=1) → one cycle of pc_hold=1, ifid_hold=1, idex_bubble=1; next cycle all 0; stall_cycles=1.
- Same, but ex_rd=0, or id_use_rs1=0 with id_rs1=5 → no stall at all outputs.
- ex_redirect=1 for one cycle while lu=1 → ifid_flush=1, idex_flush=1, idex_bubble=0, pc_hold=0; flush_count increments 0→1.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 → state_o goes 00→01; pc_hold, ifid_hold, exmem_hold and memwb_bubble are 1 for 3 cycles and 0 on the ready cycle; state returns to 00; stall_cycles=3.
- TIMEOUT=4, mem_req=1 and mem_ready held 0 → state_o=10 and fault=1 after 4 wait cycles, frozen indefinitely; a later mem_ready=1 has no effect.
- rst pulsed low asynchronously mid-MEM_WAIT (between edges) → all outputs 0 immediately; state_o=00, counters 0; normal operation after release.
